burst_stream_driver: RTL

Transmit/receive counterpart of the burst-buffer core. It plays a preloaded frame onto the core's `in_valid`/`in_data` input burst. It then captures the core's `out_valid`/`out_data` return burst into a local buffer for readback. It is used as the on-chip stimulus/loopback engine in front of the core, driven by a host-side register port.

---
 rtl/burst_stream_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/burst_stream_driver.sv
// Burst stimulus/loopback engine: plays a preloaded TX frame and captures the returned burst.
// Optional loopback compare is built when LOOPBACK_CHECK_EN is defined.
module burst_stream_driver #(
    parameter  int unsigned DW      = 16,
    parameter  int unsigned DEPTH   = 16,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic [LW-1:0] cfg_len,
    input  logic          start,
    output logic          busy,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [LW-1:0] rx_count,
    output logic          done,
    output logic          err_overflow,
    output logic          err_timeout,
    output logic          mismatch
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [CW-1:0] r_wait_cnt;
    logic [LW-1:0] r_rx_count;
    logic          r_tx_valid;
    logic [DW-1:0] r_tx_data;
    logic          r_busy;
    logic          r_done;
    logic          r_err_overflow;
    logic          r_err_timeout;

    logic [DW-1:0] r_tx_buf [DEPTH];
    logic [DW-1:0] r_rx_buf [DEPTH];

    state_t        w_state_nxt;
    logic [LW-1:0] w_len_nxt;
    logic [LW-1:0] w_idx_nxt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic [LW-1:0] w_rx_count_nxt;
    logic          w_tx_valid_nxt;
    logic [DW-1:0] w_tx_data_nxt;
    logic          w_done_nxt;
    logic          w_err_ovf_nxt;
    logic          w_err_to_nxt;
    logic          w_tx_we;
    logic          w_rx_we;
    logic [AW-1:0] w_rx_waddr;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_idx          <= '0;
            r_wait_cnt     <= '0;
            r_rx_count     <= '0;
            r_tx_valid     <= 1'b0;
            r_tx_data      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_len          <= w_len_nxt;
            r_idx          <= w_idx_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_rx_count     <= w_rx_count_nxt;
            r_tx_valid     <= w_tx_valid_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= w_done_nxt;
            r_err_overflow <= w_err_ovf_nxt;
            r_err_timeout  <= w_err_to_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_wait_cnt_nxt = r_wait_cnt;
        w_rx_count_nxt = r_rx_count;
        w_err_ovf_nxt  = r_err_overflow;
        w_err_to_nxt   = r_err_timeout;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = '0;
        w_done_nxt     = 1'b0;
        w_tx_we        = 1'b0;
        w_rx_we        = 1'b0;
        w_rx_waddr     = r_rx_count[AW-1:0];

        case (r_state)
            S_IDLE: begin
                w_tx_we = cfg_we;
                if (start && (cfg_len != '0)) begin
                    w_len_nxt      = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
                    w_idx_nxt      = '0;
                    w_rx_count_nxt = '0;
                    w_err_ovf_nxt  = 1'b0;
                    w_err_to_nxt   = 1'b0;
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = r_tx_buf[r_idx[AW-1:0]];
                w_idx_nxt      = r_idx + LW'(1);
                if (r_idx == (r_len - LW'(1))) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_valid) begin
                    w_rx_we        = 1'b1;
                    w_rx_waddr     = '0;
                    w_rx_count_nxt = LW'(1);
                    w_state_nxt    = S_RECV;
                end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_to_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    // Words beyond the buffer are dropped, only flagged
                    if (r_rx_count == LW'(DEPTH)) begin
                        w_err_ovf_nxt = 1'b1;
                    end else begin
                        w_rx_we        = 1'b1;
                        w_rx_count_nxt = r_rx_count + LW'(1);
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Buffers carry no reset so contents survive a mid-transfer reset
    always_ff @(posedge clk) begin
        if (w_tx_we) begin
            r_tx_buf[cfg_addr] <= cfg_wdata;
        end
        if (w_rx_we) begin
            r_rx_buf[w_rx_waddr] <= rx_data;
        end
    end

`ifdef LOOPBACK_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_SEND)) begin
            r_mismatch <= 1'b0;
        end else if ((w_rx_we && ({1'b0, w_rx_waddr} < r_len) &&
                      (r_tx_buf[w_rx_waddr] != rx_data)) ||
                     (w_done_nxt && (w_rx_count_nxt != r_len))) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign busy         = r_busy;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;
    assign rd_data      = r_rx_buf[rd_addr];
    assign rx_count     = r_rx_count;
    assign done         = r_done;
    assign err_overflow = r_err_overflow;
    assign err_timeout  = r_err_timeout;

endmodule
